// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - register-write scoreboard giving forwarding selects, load-use stalls and flush bubbles
module hazard_scoreboard #(
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 32,
    localparam int SW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [4:0]       dec_rd,
    input  logic             dec_wen,
    input  logic             dec_is_load,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic             dec_rs1_used,
    input  logic             dec_rs2_used,
    input  logic             flush,
    input  logic             stall_ext,
    output logic             stall,
    output logic [SW-1:0]    fwd_a,
    output logic [SW-1:0]    fwd_b,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    // Index i holds stage i+1 (index 0 is X, index DEPTH-1 is the last writeback stage).
    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_load;
    logic [4:0]       ent_rd [DEPTH];
    logic             haz_a;
    logic             haz_b;
    logic             hazard;

    // Scan oldest to youngest so the youngest live writer overwrites the select and hazard flag.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        haz_a = 1'b0;
        haz_b = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (ent_valid[k-1] && (ent_rd[k-1] != 5'd0)) begin
                if (dec_rs1_used && (ent_rd[k-1] == dec_rs1)) begin
                    fwd_a = SW'(k);
                    haz_a = ent_load[k-1] && (k < LOAD_LAT);
                end
                if (dec_rs2_used && (ent_rd[k-1] == dec_rs2)) begin
                    fwd_b = SW'(k);
                    haz_b = ent_load[k-1] && (k < LOAD_LAT);
                end
            end
        end
        hazard = haz_a | haz_b;
        stall  = dec_valid & hazard & ~flush & ~stall_ext;
    end

    // Shift the scoreboard unless frozen; flush or load-use stall inserts a bubble into stage 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid <= '0;
            ent_load  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_rd[i] <= 5'd0;
            end
        end else if (!stall_ext) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                ent_valid[i] <= ent_valid[i-1];
                ent_load[i]  <= ent_load[i-1];
                ent_rd[i]    <= ent_rd[i-1];
            end
            if (flush || stall) begin
                ent_valid[0] <= 1'b0;
                ent_load[0]  <= 1'b0;
                ent_rd[0]    <= 5'd0;
            end else begin
                ent_valid[0] <= dec_valid & dec_wen;
                ent_load[0]  <= dec_is_load;
                ent_rd[0]    <= dec_rd;
            end
        end
    end

    // Saturating performance counters; a flush takes precedence over a coincident hazard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else if (!stall_ext) begin
            if (flush) begin
                if (flush_count != {CNT_W{1'b1}}) begin
                    flush_count <= flush_count + CNT_W'(1);
                end
            end else if (stall) begin
                if (stall_count != {CNT_W{1'b1}}) begin
                    stall_count <= stall_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
